// File: rtl/commit_bus_arbiter_pkg.sv
// Shared definitions for the register-file commit bus arbiter.
package commit_bus_arbiter_pkg;

  // Width of one commit packet (RSID/WE/DST/X/Y/Z fields).
  localparam int COMMIT_PACKET_SIZE = 16;

  // Largest station count the arbiter is sized for; oLastId is 4 bits wide.
  localparam int ARB_MAX_STATIONS = 16;

  // Arbiter state: IDLE means no grant is on the bus this cycle.
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/commit_bus_arbiter_rr_pick.sv
// Round-robin priority pick: the first set request bit at or above ptr,
// wrapping past the top. The request vector is doubled so that the wrapped
// bits sit above the unwrapped ones, bits below ptr are masked off, and the
// lowest remaining bit is isolated with x & -x.
module rr_priority_pick #(
  parameter int NUM_STATIONS = 4,
  parameter int IDX_W        = 2
) (
  input  logic [NUM_STATIONS-1:0] req,
  input  logic [IDX_W-1:0]        ptr,
  output logic [NUM_STATIONS-1:0] onehot,
  output logic [IDX_W-1:0]        idx
);

  localparam int DW = 2 * NUM_STATIONS;

  logic [DW-1:0] dbl;
  logic [DW-1:0] below;
  logic [DW-1:0] cand;
  logic [DW-1:0] iso;

  assign dbl    = {req, req};
  assign below  = (DW'(1) << ptr) - DW'(1);
  assign cand   = dbl & ~below;
  assign iso    = cand & (~cand + DW'(1));
  assign onehot = iso[NUM_STATIONS-1:0] | iso[DW-1:NUM_STATIONS];

  // Encode the one-hot winner into a station index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_STATIONS; i++) begin
      if (onehot[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/commit_bus_arbiter.sv
// Shares the register-file commit bus between the reservation stations.
// A registered one-hot grant is issued round-robin; the winner's packet is
// captured at the end of its grant cycle and broadcast the next cycle.
module commit_bus_arbiter
  import commit_bus_arbiter_pkg::*;
#(
  parameter int NUM_STATIONS = 4,
  parameter int PKT_W        = COMMIT_PACKET_SIZE
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_STATIONS-1:0]       iRequest,
  input  logic [NUM_STATIONS*PKT_W-1:0] iPacket,
  input  logic                          iStall,
  output logic [NUM_STATIONS-1:0]       oGrant,
  output logic                          oCommitValid,
  output logic [PKT_W-1:0]              oCommitData,
  output logic [3:0]                    oLastId
);

  localparam int IDX_W = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1;

  arb_state_e              state, state_next;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        grant_idx;
  logic [NUM_STATIONS-1:0] mask;
  logic [NUM_STATIONS-1:0] eligible;
  logic [NUM_STATIONS-1:0] win_onehot;
  logic [IDX_W-1:0]        win_idx;
  logic                    fire;

  // A granted station still shows its request during the grant cycle; the
  // mask hides it so the same station is never granted twice in a row.
  assign eligible = iRequest & ~mask;

  rr_priority_pick #(
    .NUM_STATIONS (NUM_STATIONS),
    .IDX_W        (IDX_W)
  ) u_pick (
    .req    (eligible),
    .ptr    (ptr),
    .onehot (win_onehot),
    .idx    (win_idx)
  );

  // Next state: grant whenever someone is eligible and the write port is free.
  always_comb begin
    state_next = ARB_IDLE;
    fire       = 1'b0;
    case (state)
      ARB_IDLE, ARB_GRANT: begin
        if (eligible != '0 && !iStall) begin
          fire       = 1'b1;
          state_next = ARB_GRANT;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        fire       = 1'b0;
      end
    endcase
  end

  // Grant, pointer and mask registers; the pointer only moves on a grant.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= ARB_IDLE;
      oGrant    <= '0;
      mask      <= '0;
      ptr       <= '0;
      grant_idx <= '0;
    end else begin
      state <= state_next;
      if (fire) begin
        oGrant    <= win_onehot;
        mask      <= win_onehot;
        grant_idx <= win_idx;
        ptr       <= (win_idx == IDX_W'(NUM_STATIONS - 1)) ? '0 : win_idx + 1'b1;
      end else begin
        oGrant <= '0;
        mask   <= '0;
      end
    end
  end

  // Capture the granted station's packet at the end of its grant cycle.
  // Independent of iStall so an in-flight commit always completes.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oCommitValid <= 1'b0;
      oCommitData  <= '0;
      oLastId      <= '0;
    end else begin
      oCommitValid <= (state == ARB_GRANT);
      if (state == ARB_GRANT) begin
        oCommitData <= iPacket[grant_idx*PKT_W +: PKT_W];
        oLastId     <= 4'(grant_idx);
      end
    end
  end

endmodule

// File: tb/tb_commit_bus_arbiter.sv
// Directed bench for commit_bus_arbiter: reset, rotation, stall, single
// requester, pointer wrap and asynchronous reset mid-commit.
module tb_commit_bus_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic             Clock;
  logic             Reset;
  logic [N-1:0]     iRequest;
  logic [N*W-1:0]   iPacket;
  logic             iStall;
  logic [N-1:0]     oGrant;
  logic             oCommitValid;
  logic [W-1:0]     oCommitData;
  logic [3:0]       oLastId;

  logic [W-1:0]     pkt [N];

  int checks = 0;
  int errors = 0;

  assign iPacket = {pkt[3], pkt[2], pkt[1], pkt[0]};

  commit_bus_arbiter #(.NUM_STATIONS(N), .PKT_W(W)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iRequest     (iRequest),
    .iPacket      (iPacket),
    .iStall       (iStall),
    .oGrant       (oGrant),
    .oCommitValid (oCommitValid),
    .oCommitData  (oCommitData),
    .oLastId      (oLastId)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] exp_rot [5];
    logic [3:0]   exp_id  [5];
    exp_rot[0] = 4'b0001; exp_rot[1] = 4'b0010; exp_rot[2] = 4'b0100;
    exp_rot[3] = 4'b1000; exp_rot[4] = 4'b0001;
    exp_id[0] = 4'd0; exp_id[1] = 4'd1; exp_id[2] = 4'd2; exp_id[3] = 4'd3; exp_id[4] = 4'd0;

    pkt[0] = 16'h1111; pkt[1] = 16'h2222; pkt[2] = 16'h3333; pkt[3] = 16'h4444;
    Reset = 1'b1; iRequest = 4'b1111; iStall = 1'b0;

    // Reset held with every station requesting.
    tick(); tick();
    chk("reset_grant", oGrant, 4'b0000);
    chk("reset_valid", oCommitValid, 1'b0);
    chk("reset_data",  oCommitData, 16'h0);
    chk("reset_lastid", oLastId, 4'd0);
    Reset = 1'b0;

    // All requesting: rotation 0,1,2,3,0 with data one cycle behind.
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rot_grant%0d", k), oGrant, exp_rot[k]);
      if (k == 0) chk("rot_first_valid", oCommitValid, 1'b0);
      else begin
        chk($sformatf("rot_valid%0d", k), oCommitValid, 1'b1);
        chk($sformatf("rot_id%0d", k), oLastId, exp_id[k-1]);
        chk($sformatf("rot_data%0d", k), oCommitData, pkt[exp_id[k-1]]);
      end
    end
    tick();
    chk("rot_grant5", oGrant, 4'b0010);
    chk("rot_id4", oLastId, 4'd0);
    iRequest = 4'b0000;
    tick();
    chk("drain_grant", oGrant, 4'b0000);
    chk("drain_valid", oCommitValid, 1'b1);
    chk("drain_id", oLastId, 4'd1);
    tick();
    chk("idle_valid", oCommitValid, 1'b0);
    chk("idle_data_hold", oCommitData, 16'h2222);

    // Stall for 3 cycles with stations 0,1 requesting; pointer sits at 2.
    iRequest = 4'b0011; iStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_grant%0d", k), oGrant, 4'b0000);
      chk($sformatf("stall_valid%0d", k), oCommitValid, 1'b0);
    end
    iStall = 1'b0;
    tick();
    chk("unstall_grant", oGrant, 4'b0001);
    tick();
    chk("unstall_grant2", oGrant, 4'b0010);
    chk("unstall_data", oCommitData, 16'h1111);
    iRequest = 4'b0000;
    tick();
    chk("unstall_data2", oCommitData, 16'h2222);
    tick();

    // Single requester, station 2 with packet 0xABC; pointer at 2.
    pkt[2] = 16'h0ABC; iRequest = 4'b0100;
    tick();
    chk("single_grant", oGrant, 4'b0100);
    chk("single_valid0", oCommitValid, 1'b0);
    tick();
    chk("single_no_regrant", oGrant, 4'b0000);
    chk("single_valid1", oCommitValid, 1'b1);
    chk("single_data", oCommitData, 16'h0ABC);
    chk("single_id", oLastId, 4'd2);
    iRequest = 4'b0000;
    tick();

    // Pointer now 3, stations 0 and 2 requesting: wrap to 0, then 2.
    iRequest = 4'b0101;
    tick();
    chk("wrap_grant0", oGrant, 4'b0001);
    tick();
    chk("wrap_grant1", oGrant, 4'b0100);
    chk("wrap_id0", oLastId, 4'd0);
    // Stall right after a grant: the in-flight commit still completes.
    iStall = 1'b1;
    tick();
    chk("stall_inflight_grant", oGrant, 4'b0000);
    chk("stall_inflight_valid", oCommitValid, 1'b1);
    chk("stall_inflight_data", oCommitData, 16'h0ABC);
    iStall = 1'b0; iRequest = 4'b0000;
    tick();

    // Reset asserted mid-cycle while a commit is on the bus.
    iRequest = 4'b0010;
    tick();
    chk("pre_reset_grant", oGrant, 4'b0010);
    tick();
    chk("pre_reset_valid", oCommitValid, 1'b1);
    iRequest = 4'b0110;
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_valid", oCommitValid, 1'b0);
    chk("async_reset_grant", oGrant, 4'b0000);
    chk("async_reset_id", oLastId, 4'd0);
    tick();
    Reset = 1'b0;
    tick();
    chk("post_reset_ptr0_grant", oGrant, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
